// File: rtl/fp_pkg.sv
// Shared constants, field positions and types for the FP adder's post-add normalizer.
// Imported by the normalizer interface and the normalizer itself.
package fp_pkg;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int SUM_W  = MANT_W + 3;

  localparam logic [EXP_W-1:0] EXP_MAX      = '1;
  localparam logic [EXP_W-1:0] EXP_MIN_NORM = EXP_W'(1);

  // Field positions inside sum_in: carry, significand, guard, round.
  localparam int CARRY_BIT = SUM_W - 1;
  localparam int SIG_MSB   = SUM_W - 2;
  localparam int SIG_LSB   = 2;
  localparam int GUARD_BIT = 1;
  localparam int ROUND_BIT = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVAL  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } norm_state_t;

  typedef struct packed {
    logic [MANT_W-1:0] mantissa;
    logic [EXP_W-1:0]  exponent;
    logic              guard;
    logic              round;
    logic              sticky;
    logic              zero;
    logic              overflow;
    logic              underflow;
  } norm_result_t;

endpackage

// File: rtl/normalization_unit_if.sv
// Request/result bundle between the significand adder, the normalizer and rounding_unit.
// The master side issues requests; the slave side is the normalizer.
interface normalization_unit_if;
  import fp_pkg::*;

  logic              enable;
  logic [SUM_W-1:0]  sum_in;
  logic              sticky_in;
  logic [EXP_W-1:0]  exponent_in;

  logic [MANT_W-1:0] mantissa;
  logic [EXP_W-1:0]  exponent;
  logic              guard;
  logic              round;
  logic              sticky;
  logic              done;
  logic              busy;
  logic              zero;
  logic              overflow;
  logic              underflow;

  modport master (
    output enable, sum_in, sticky_in, exponent_in,
    input  mantissa, exponent, guard, round, sticky,
    input  done, busy, zero, overflow, underflow
  );

  modport slave (
    input  enable, sum_in, sticky_in, exponent_in,
    output mantissa, exponent, guard, round, sticky,
    output done, busy, zero, overflow, underflow
  );

endinterface

// File: rtl/normalization_unit.sv
// Post-add normalizer: one-step right shift on carry-out, iterative one-bit-per-cycle
// left shift otherwise, with zero/overflow/underflow detection for rounding_unit.
module normalization_unit
  import fp_pkg::*;
(
  input logic                  Clk,
  input logic                  Reset,
  normalization_unit_if.slave  bus
);

  norm_state_t       state, state_next;
  logic [SUM_W-1:0]  work, work_next;
  logic [EXP_W-1:0]  exp_w, exp_w_next;
  logic              stk, stk_next;
  norm_result_t      res, res_next;
  logic              done_r, done_next;

  logic [EXP_W:0]    exp_inc;
  logic [EXP_W-1:0]  exp_dec;
  logic [SUM_W-1:0]  shifted;

  // The extra bit on the increment lets the overflow compare see a wrapped exponent.
  assign exp_inc = {1'b0, exp_w} + (EXP_W+1)'(1);
  assign exp_dec = exp_w - EXP_W'(1);
  assign shifted = {1'b0, work[SUM_W-3:0], 1'b0};

  always_comb begin
    // NOTE: every next value defaults to its current value first, so no branch can infer a latch.
    state_next = state;
    work_next  = work;
    exp_w_next = exp_w;
    stk_next   = stk;
    res_next   = res;
    done_next  = (state == S_DONE);

    case (state)
      S_IDLE: begin
        if (bus.enable) begin
          work_next          = bus.sum_in;
          stk_next           = bus.sticky_in;
          exp_w_next         = bus.exponent_in;
          res_next.zero      = 1'b0;
          res_next.overflow  = 1'b0;
          res_next.underflow = 1'b0;
          state_next         = S_EVAL;
        end
      end

      S_EVAL: begin
        if (work == '0 && !stk) begin
          res_next      = '0;
          res_next.zero = 1'b1;
          state_next    = S_DONE;
        end else if (work[CARRY_BIT]) begin
          if (exp_inc >= {1'b0, EXP_MAX}) begin
            // Saturate to infinity: significand and rounding bits are discarded.
            res_next          = '0;
            res_next.exponent = EXP_MAX;
            res_next.overflow = 1'b1;
          end else begin
            res_next.mantissa = work[CARRY_BIT:SIG_LSB+1];
            res_next.guard    = work[SIG_LSB];
            res_next.round    = work[GUARD_BIT];
            res_next.sticky   = work[ROUND_BIT] | stk;
            res_next.exponent = exp_inc[EXP_W-1:0];
          end
          state_next = S_DONE;
        end else if (work[SIG_MSB]) begin
          res_next.mantissa = work[SIG_MSB:SIG_LSB];
          res_next.guard    = work[GUARD_BIT];
          res_next.round    = work[ROUND_BIT];
          res_next.sticky   = stk;
          res_next.exponent = exp_w;
          state_next        = S_DONE;
        end else begin
          state_next = S_SHIFT;
        end
      end

      S_SHIFT: begin
        work_next  = shifted;
        exp_w_next = exp_dec;
        if (shifted[SIG_MSB] || exp_dec <= EXP_MIN_NORM) begin
          res_next.mantissa = shifted[SIG_MSB:SIG_LSB];
          res_next.guard    = shifted[GUARD_BIT];
          res_next.round    = shifted[ROUND_BIT];
          res_next.sticky   = stk;
          if (shifted[SIG_MSB]) begin
            res_next.exponent = exp_dec;
          end else begin
            // Ran out of exponent before finding the leading one: denormal result.
            res_next.exponent  = '0;
            res_next.underflow = 1'b1;
          end
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (Reset) begin
      state  <= S_IDLE;
      work   <= '0;
      exp_w  <= '0;
      stk    <= 1'b0;
      res    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_next;
      work   <= work_next;
      exp_w  <= exp_w_next;
      stk    <= stk_next;
      res    <= res_next;
      done_r <= done_next;
    end
  end

  assign bus.mantissa  = res.mantissa;
  assign bus.exponent  = res.exponent;
  assign bus.guard     = res.guard;
  assign bus.round     = res.round;
  assign bus.sticky    = res.sticky;
  assign bus.zero      = res.zero;
  assign bus.overflow  = res.overflow;
  assign bus.underflow = res.underflow;
  assign bus.done      = done_r;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: doc/normalization_unit.md
Name: normalization_unit

Overview:
- Post-add normalizer sitting between the significand adder/subtractor and rounding_unit in the 32-bit FP adder.
- Takes the raw 27-bit sum (carry, 24-bit significand, guard, round), the sticky bit and the biased exponent.
- Produces a normalized 24-bit mantissa, adjusted exponent and guard/round/sticky bits, whose names match rounding_unit's inputs for direct connection.
- Left normalization is iterative, one bit per cycle, under a small FSM; done drives rounding_unit's enable.

Parameters:
- MANT_W, 24, significand width including hidden bit.
- EXP_W, 8, biased exponent width.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- enable  input  1  start request; sampled only in IDLE.
- sum_in  input  MANT_W+3  bit26 carry, bits25:2 significand, bit1 guard, bit0 round.
- sticky_in  input  1  OR of bits shifted out during alignment.
- exponent_in  input  EXP_W  biased exponent of the larger operand.
- mantissa  output  MANT_W  normalized significand, hidden bit at MSB.
- exponent  output  EXP_W  adjusted biased exponent.
- guard, round, sticky  output  1 each  rounding bits for rounding_unit.
- done  output  1  one-cycle pulse; outputs valid from this cycle until the next capture.
- busy  output  1  high in any state other than IDLE.
- zero, overflow, underflow  output  1 each  status flags, valid with done.

Behaviour:
- Reset: all outputs 0, internal registers 0, state IDLE. This applies in any state, including mid-shift. A shift in progress is aborted and done is not asserted.
- IDLE: on an edge with enable=1, capture sum_in, sticky_in and exponent_in, then go to EVAL. enable is ignored outside IDLE; deasserting it mid-operation has no effect.
- EVAL, checks in priority order:
  - All captured bits and sticky are 0: mantissa=0, exponent=0, guard=round=sticky=0, zero=1. Go to DONE.
  - Carry=1: right shift by 1. mantissa=sum[26:3], guard=sum[2], round=sum[1], sticky=sum[0]|sticky_in, exponent+1.
    - If the new exponent equals 255: overflow=1, mantissa=0, guard=round=sticky=0, exponent=255 (infinity).
    - Go to DONE.
  - Bit25=1: pass through unchanged. Go to DONE.
  - Otherwise go to SHIFT.
- SHIFT, one bit per cycle:
  - Shift {significand, guard, round} left by 1, with 0 entering round. sticky is unchanged.
  - exponent decrements by 1.
  - Stay in SHIFT while the new bit25=0 and the new exponent>1.
  - Exit to DONE when bit25=1.
  - If the exponent reaches 1 with bit25 still 0: set exponent output to 0, underflow=1 (denormal). Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. Output registers hold until the next capture. Flags clear on the next capture.
- Latency:
  - done rises 2 edges after the capture edge for the zero, carry and pass-through cases.
  - done rises 2+k edges after capture for k left shifts. Maximum k is 25 (leading one in the round bit).
- Exponent arithmetic is EXP_W bits. Increment is bounded by the overflow check; decrement is bounded at 1 by the exit condition. Wrap-around is impossible.
- Back-to-back operation: enable high in the cycle after done starts a new capture. Minimum issue interval is 3 cycles.

Decomposition:
- Shared package fp_pkg:
  - MANT_W, EXP_W, EXP_MAX (255), EXP_MIN_NORM (1).
  - FSM state encoding for IDLE, EVAL, SHIFT, DONE.
  - The sum_in field bit indices.
- No sub-module is needed. A single FSM plus a datapath register; a leading-zero counter is deliberately not used.

Test Plan:
- Carry: sum_in={1,24'hFFFFFF,1,1}, sticky_in=0, exponent_in=130 -> mantissa=24'hFFFFFF, guard=1, round=1, sticky=1, exponent=131; done 2 edges after capture.
- Pass-through: sum_in={0,24'hFFFFF0,0,0}, exponent_in=130 -> mantissa=24'hFFFFF0, g/r/s=0, exponent=130, no flags; done after 2 edges.
- Left shift by 3: sum_in={0,24'h1FFFFF,1,0}, sticky_in=1, exponent_in=130 -> mantissa=24'hFFFFFC, guard=0, round=0, sticky=1, exponent=127; done after 5 edges; busy high throughout.
- Zero and overflow:
  - All-zero input -> zero=1, mantissa=0, exponent=0.
  - Carry with exponent_in=254 -> overflow=1, exponent=255, mantissa=0.
- Underflow: sum_in={0,24'h000100,0,0}, exponent_in=3 -> mantissa=24'h000400, exponent=0, underflow=1; done after 4 edges.
- Reset mid-shift: start the 3-shift case and assert Reset after the second edge -> all outputs 0, no done pulse. A new enable next cycle completes normally.
